multiply_sequencer: RTL and testbench
=====================================

Name: multiply_sequencer

Overview:
Multi-cycle shift-and-add multiplication controller for the calculator datapath. It replaces the combinational multiply path with a deterministic WIDTH-cycle iterative engine. It accepts a Start request from the operation-select logic, latches both operands, and sequences one partial-product step per clock. It returns a WIDTH-bit result with an overflow flag and a one-cycle Done strobe.

Parameters:
WIDTH, 21, operand and result width in bits (unsigned magnitude)
CNT_W, 5, step-counter width; must satisfy 2^CNT_W >= WIDTH

Ports:
Clock  input  1  single system clock; all state changes on the rising edge
Reset_n  input  1  asynchronous, active-low reset
Start  input  1  request a multiply; sampled only in IDLE
Clear  input  1  synchronous abort; returns the block to IDLE
Number0  input  WIDTH  multiplicand; latched on accepted Start
Number1  input  WIDTH  multiplier; latched on accepted Start
Busy  output  1  high while in RUN
Done  output  1  one-cycle strobe; Result and Overflow are valid from this cycle
Result  output  WIDTH  low WIDTH bits of the product; held until the next completion
Overflow  output  1  high if the product does not fit in WIDTH bits; held with Result

Behaviour:
- Reset (Reset_n low, asynchronous):
  - state=IDLE; Busy=0, Done=0, Result=0, Overflow=0.
  - Internal acc, mcand, mplier and count are all cleared.
- States: IDLE, RUN, DONE. Outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - If Start=1 and Clear=0 at an edge: mcand = zero-extended Number0 (2*WIDTH bits), mplier = Number1, acc = 0, count = 0, go to RUN.
  - Otherwise remain in IDLE.
- RUN, one step per edge:
  - acc_next = acc + (mplier[0] ? mcand : 0).
  - mcand <<= 1; mplier >>= 1; count += 1.
  - When count == WIDTH-1 at the edge: Result <= acc_next[WIDTH-1:0], Overflow <= |acc_next[2*WIDTH-1:WIDTH], go to DONE.
  - Otherwise acc <= acc_next and stay in RUN.
- DONE: Done=1 for exactly this cycle. Go to IDLE at the next edge unconditionally. Start seen in DONE is ignored, not queued.
- Latency:
  - Start accepted at edge k gives Done high from edge k+WIDTH to edge k+WIDTH+1.
  - Fixed WIDTH cycles; no early exit for zero operands.
- Busy=1 only in RUN. Busy=0 in IDLE and DONE.
- Start while Busy=1 or Done=1: ignored, and the latched operands are unaffected.
- Operand inputs are don't-care except on the accepting edge.
- Clear=1 at any edge:
  - Next state is IDLE; Busy=0, Done=0; count=0.
  - Result and Overflow keep their last completed values.
  - Clear has priority over Start in the same cycle.
- Reset_n asserted mid-RUN: immediate return to the reset values above, with no Done pulse.
- Arithmetic:
  - Unsigned.
  - The accumulator is 2*WIDTH bits wide, so it cannot wrap internally.
  - Overflow is purely a width check on the final product. Result is the truncated low half regardless of Overflow.
- Back-to-back throughput: the earliest next Start is accepted at the edge after DONE (the IDLE cycle). Minimum period is WIDTH+2 cycles.

Test Plan:
- Reset_n low, then high; Number0=3, Number1=5, Start pulse at edge k -> Busy=1 for 21 cycles; Done=1 only in cycle k+21; Result=15, Overflow=0.
- Number0=0x1FFFFF, Number1=2 -> Result=0x1FFFFE, Overflow=1. Then Number0=0x400, Number1=0x7FF -> Result=0x1FFC00, Overflow=0.
- Number0=0, Number1=0x1FFFFF -> latency is still 21 cycles; Result=0, Overflow=0. Also check Number1=1 returns Number0 unchanged.
- Start re-pulsed at cycles k+3 and k+21 with different operands -> both ignored; first result is unchanged; the next Start is accepted only at the following IDLE edge.
- Clear at k+10 -> Busy=0 next cycle, no Done, Result keeps the prior value. Clear and Start in the same cycle -> stays IDLE.
- Reset_n pulsed low asynchronously mid-RUN (between edges) -> Busy, Done, Result and Overflow go to 0 immediately; no Done follows after release.

Source files
------------

// File: rtl/multiply_sequencer_if.sv
// Handshake and operand/result bundle between the operation-select logic
// (master) and the shift-and-add multiply sequencer (slave).
interface multiply_sequencer_if #(
    parameter int WIDTH = 21
);
    logic             Start;
    logic             Clear;
    logic [WIDTH-1:0] Number0;
    logic [WIDTH-1:0] Number1;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic             Overflow;

    modport master (
        output Start, Clear, Number0, Number1,
        input  Busy, Done, Result, Overflow
    );

    modport slave (
        input  Start, Clear, Number0, Number1,
        output Busy, Done, Result, Overflow
    );
endinterface

// File: rtl/multiply_sequencer.sv
// Iterative unsigned shift-and-add multiplier: one partial-product step per
// clock, fixed WIDTH-cycle latency, registered Result/Overflow and a
// one-cycle Done strobe decoded from the DONE state.
module multiply_sequencer #(
    parameter int WIDTH = 21,
    parameter int CNT_W = 5
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    multiply_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t                 state_q,  state_d;
    logic [2*WIDTH-1:0]     acc_q,    acc_d;
    logic [2*WIDTH-1:0]     mcand_q,  mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [CNT_W-1:0]       count_q,  count_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   ovf_q,    ovf_d;
    logic [2*WIDTH-1:0]     acc_next;

    // Partial-product sum for the current step; the double-width accumulator
    // cannot wrap, so overflow is just a check of the upper half at the end.
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Next-state and datapath update; Clear overrides everything but keeps
    // the last completed Result/Overflow.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        result_d = result_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.Start && !bus.Clear) begin
                    mcand_d  = {{WIDTH{1'b0}}, bus.Number0};
                    mplier_d = bus.Number1;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_W'(1);
                if (count_q == LAST_STEP) begin
                    result_d = acc_next[WIDTH-1:0];
                    ovf_d    = |acc_next[2*WIDTH-1:WIDTH];
                    state_d  = DONE;
                end else begin
                    acc_d    = acc_next;
                end
            end
            DONE: begin
                // Start seen here is deliberately dropped, not queued.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.Clear) begin
            state_d  = IDLE;
            count_d  = '0;
            result_d = result_q;
            ovf_d    = ovf_q;
        end
    end

    // State, operand and result registers with asynchronous active-low reset.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.Busy     = (state_q == RUN);
    assign bus.Done     = (state_q == DONE);
    assign bus.Result   = result_q;
    assign bus.Overflow = ovf_q;

endmodule

// File: tb/tb_multiply_sequencer.sv
// Self-checking bench for multiply_sequencer: directed and random multiplies
// compared against a plain-arithmetic product model.
module tb_multiply_sequencer;

    localparam int W = 21;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    multiply_sequencer_if #(.WIDTH(W)) mif ();

    multiply_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full unsigned product, truncated result, width-overflow flag.
    function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        p = {43'd0, a} * {43'd0, b};
        return p[W-1:0];
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        p = {43'd0, a} * {43'd0, b};
        return (p >> W) != 64'd0;
    endfunction

    // Issues one multiply at the next edge (caller is idle, #1 past an edge)
    // and checks busy/done timing, result, and the return to idle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [W-1:0] er;
        logic         eo;
        er = ref_result(a, b);
        eo = ref_ovf(a, b);
        mif.Start   = 1'b1;
        mif.Number0 = a;
        mif.Number1 = b;
        @(posedge clk); #1;
        mif.Start   = 1'b0;
        mif.Number0 = W'($urandom);
        mif.Number1 = W'($urandom);
        n_chk++;
        if (mif.Busy !== 1'b1 || mif.Done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s accept: busy=%b done=%b required busy=1 done=0", tag, mif.Busy, mif.Done);
        end
        for (int i = 1; i <= W; i++) begin
            @(posedge clk); #1;
            mif.Number0 = W'($urandom);
            mif.Number1 = W'($urandom);
            n_chk++;
            if (i < W) begin
                if (mif.Busy !== 1'b1 || mif.Done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s run cycle %0d: busy=%b done=%b required busy=1 done=0", tag, i, mif.Busy, mif.Done);
                end
            end else begin
                if (mif.Busy !== 1'b0 || mif.Done !== 1'b1 || mif.Result !== er || mif.Overflow !== eo) begin
                    n_fail++;
                    $display("FAIL %s done: busy=%b done=%b result=%h ovf=%b required busy=0 done=1 result=%h ovf=%b",
                             tag, mif.Busy, mif.Done, mif.Result, mif.Overflow, er, eo);
                end
            end
        end
        @(posedge clk); #1;
        n_chk++;
        if (mif.Busy !== 1'b0 || mif.Done !== 1'b0 || mif.Result !== er || mif.Overflow !== eo) begin
            n_fail++;
            $display("FAIL %s idle/hold: busy=%b done=%b result=%h ovf=%b required 0 0 %h %b",
                     tag, mif.Busy, mif.Done, mif.Result, mif.Overflow, er, eo);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        mif.Start   = 1'b0;
        mif.Clear   = 1'b0;
        mif.Number0 = '0;
        mif.Number1 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (mif.Busy !== 1'b0 || mif.Done !== 1'b0 || mif.Result !== '0 || mif.Overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b result=%h ovf=%b required all zero",
                     mif.Busy, mif.Done, mif.Result, mif.Overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (mif.Busy !== 1'b0 || mif.Done !== 1'b0 || mif.Result !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy=%b done=%b result=%h required 0 0 0", mif.Busy, mif.Done, mif.Result);
        end
    endtask

    task automatic test_directed();
        run_op(W'(3), W'(5), "mul_3x5");
        run_op(W'(21'h1FFFFF), W'(2), "mul_max_x2");
        run_op(W'(21'h400), W'(21'h7FF), "mul_400x7ff");
        run_op(W'(0), W'(21'h1FFFFF), "mul_zero");
        run_op(W'(21'h0ABCDE), W'(1), "mul_identity");
        run_op(W'(21'h1FFFFF), W'(21'h1FFFFF), "mul_max_max");
        run_op(W'(21'h100000), W'(2), "mul_edge_ovf");
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        for (int n = 0; n < 16; n++) begin
            a = W'($urandom);
            b = W'($urandom);
            if (n % 4 == 1) b = W'($urandom_range(0, 1023));
            if (n % 4 == 2) a = W'($urandom_range(0, 2047));
            run_op(a, b, "mul_random");
        end
    endtask

    // Start pulses during RUN and DONE must be dropped and must not disturb
    // the operands in flight; the IDLE cycle afterwards accepts a new Start.
    task automatic test_ignore_start();
        logic [W-1:0] a, b, er;
        logic         eo;
        a  = W'($urandom_range(1, 21'h1FFFFF));
        b  = W'($urandom_range(1, 4095));
        er = ref_result(a, b);
        eo = ref_ovf(a, b);
        mif.Start   = 1'b1;
        mif.Number0 = a;
        mif.Number1 = b;
        @(posedge clk); #1;
        for (int i = 1; i <= W + 1; i++) begin
            mif.Start   = (i == 3 || i == W || i == W + 1);
            mif.Number0 = W'($urandom);
            mif.Number1 = W'($urandom);
            @(posedge clk); #1;
            if (i == W) begin
                n_chk++;
                if (mif.Done !== 1'b1 || mif.Result !== er || mif.Overflow !== eo) begin
                    n_fail++;
                    $display("FAIL ignore_start result: done=%b result=%h ovf=%b required 1 %h %b",
                             mif.Done, mif.Result, mif.Overflow, er, eo);
                end
            end
            if (i == W + 1) begin
                n_chk++;
                if (mif.Busy !== 1'b0 || mif.Done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ignore_start_in_done: busy=%b done=%b required 0 0", mif.Busy, mif.Done);
                end
            end
        end
        mif.Start = 1'b0;
        run_op(W'($urandom), W'($urandom), "accept_after_done");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            run_op(W'($urandom), W'($urandom), "back_to_back");
        end
    endtask

    task automatic test_clear();
        logic [W-1:0] prev_r;
        logic         prev_o;
        int           done_seen;
        run_op(W'(21'h1FFFFF), W'(3), "clear_prep");
        prev_r = ref_result(W'(21'h1FFFFF), W'(3));
        prev_o = ref_ovf(W'(21'h1FFFFF), W'(3));
        mif.Start   = 1'b1;
        mif.Number0 = W'(7);
        mif.Number1 = W'(9);
        @(posedge clk); #1;
        mif.Start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        mif.Clear = 1'b1;
        @(posedge clk); #1;
        mif.Clear = 1'b0;
        n_chk++;
        if (mif.Busy !== 1'b0 || mif.Done !== 1'b0 || mif.Result !== prev_r || mif.Overflow !== prev_o) begin
            n_fail++;
            $display("FAIL clear_abort: busy=%b done=%b result=%h ovf=%b required 0 0 %h %b",
                     mif.Busy, mif.Done, mif.Result, mif.Overflow, prev_r, prev_o);
        end
        done_seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (mif.Done !== 1'b0 || mif.Busy !== 1'b0) done_seen++;
        end
        n_chk++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL clear_no_done: activity cycles=%0d required 0", done_seen);
        end
        mif.Start   = 1'b1;
        mif.Clear   = 1'b1;
        mif.Number0 = W'(5);
        mif.Number1 = W'(5);
        @(posedge clk); #1;
        mif.Start = 1'b0;
        mif.Clear = 1'b0;
        n_chk++;
        if (mif.Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_beats_start: busy=%b required 0", mif.Busy);
        end
        @(posedge clk); #1;
        n_chk++;
        if (mif.Busy !== 1'b0 || mif.Done !== 1'b0 || mif.Result !== prev_r) begin
            n_fail++;
            $display("FAIL clear_start_idle: busy=%b done=%b result=%h required 0 0 %h",
                     mif.Busy, mif.Done, mif.Result, prev_r);
        end
    endtask

    task automatic test_async_reset();
        int activity;
        run_op(W'(21'h1FFFFF), W'(21'h1FFFFF), "areset_prep");
        mif.Start   = 1'b1;
        mif.Number0 = W'(123);
        mif.Number1 = W'(456);
        @(posedge clk); #1;
        mif.Start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (mif.Busy !== 1'b0 || mif.Done !== 1'b0 || mif.Result !== '0 || mif.Overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b done=%b result=%h ovf=%b required all zero",
                     mif.Busy, mif.Done, mif.Result, mif.Overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        activity = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (mif.Done !== 1'b0 || mif.Busy !== 1'b0) activity++;
        end
        n_chk++;
        if (activity != 0) begin
            n_fail++;
            $display("FAIL async_reset_no_done: activity cycles=%0d required 0", activity);
        end
        run_op(W'(11), W'(13), "after_async_reset");
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_clear();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
